// File: rtl/iob_eth_mdio.sv
`default_nettype none
// ============================================================================
// Module      : iob_eth_mdio
// Description : Clause-22 MDIO/MDC management master with optional link
//               polling, enabled by defining IOB_ETH_MDIO_SCAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_eth_mdio #(
   parameter int unsigned CLK_DIV  = 20,
   parameter logic [4:0]  SCAN_REG = 5'd1
) (
   input  logic        clk_i,
   input  logic        arst_n_i,
   input  logic        cke_i,
   input  logic        start_i,
   input  logic        op_rd_i,
   input  logic [4:0]  phy_addr_i,
   input  logic [4:0]  reg_addr_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        ta_err_o,
   input  logic        scan_en_i,
   input  logic [4:0]  scan_phy_addr_i,
   output logic        nvalid_o,
   output logic        linkfail_o,
   output logic        mdc_o,
   output logic        mdio_o,
   output logic        mdio_oe_o,
   input  logic        mdio_i
);

   localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_CMD  = 3'd2,
      S_TA   = 3'd3,
      S_DATA = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic [5:0]       r_bit, w_bit_nxt;
   logic [62:0]      r_shift, w_shift_nxt;
   logic [15:0]      r_rx, w_rx_nxt;
   logic [15:0]      r_rdata, w_rdata_nxt;
   logic             r_mdc, w_mdc_nxt;
   logic             r_mdio, w_mdio_nxt;
   logic             r_oe, w_oe_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_rd, w_rd_nxt;
   logic             r_ta_bad, w_ta_bad_nxt;
   logic             r_ta_err, w_ta_err_nxt;

   logic             w_go, w_go_rd;
   logic [4:0]       w_go_phy, w_go_reg;
   logic [15:0]      w_go_wd;
   logic [63:0]      w_frame;

`ifdef IOB_ETH_MDIO_SCAN_EN
   logic r_scan, w_scan_nxt;
   logic r_nvalid, w_nvalid_nxt;
   logic r_linkfail, w_linkfail_nxt;
   logic r_scan_en_q;
   logic r_scan_pend, w_scan_pend_nxt;
   logic w_go_scan;
`else
   logic w_unused_scan;
   assign w_unused_scan = ^{scan_en_i, scan_phy_addr_i, SCAN_REG};
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_div_nxt    = r_div;
      w_bit_nxt    = r_bit;
      w_shift_nxt  = r_shift;
      w_rx_nxt     = r_rx;
      w_rdata_nxt  = r_rdata;
      w_mdc_nxt    = r_mdc;
      w_mdio_nxt   = r_mdio;
      w_oe_nxt     = r_oe;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_rd_nxt     = r_rd;
      w_ta_bad_nxt = r_ta_bad;
      w_ta_err_nxt = r_ta_err;
      w_go         = 1'b0;
      w_go_rd      = op_rd_i;
      w_go_phy     = phy_addr_i;
      w_go_reg     = reg_addr_i;
      w_go_wd      = wdata_i;
`ifdef IOB_ETH_MDIO_SCAN_EN
      w_scan_nxt      = r_scan;
      w_nvalid_nxt    = r_nvalid;
      w_linkfail_nxt  = r_linkfail;
      w_scan_pend_nxt = r_scan_pend | (r_scan_en_q & ~scan_en_i);
      w_go_scan       = 1'b0;
      // A fall of scan_en_i invalidates the link status once the FSM is idle
      if (r_state == S_IDLE && w_scan_pend_nxt) begin
         w_nvalid_nxt    = 1'b1;
         w_scan_pend_nxt = 1'b0;
      end
`endif

      if ((r_state == S_IDLE || r_state == S_DONE) && start_i) begin
         w_go = 1'b1;
      end
`ifdef IOB_ETH_MDIO_SCAN_EN
      else if (r_state == S_IDLE && scan_en_i) begin
         w_go      = 1'b1;
         w_go_scan = 1'b1;
         w_go_rd   = 1'b1;
         w_go_phy  = scan_phy_addr_i;
         w_go_reg  = SCAN_REG;
         w_go_wd   = 16'hFFFF;
      end
`endif

      w_frame = {32'hFFFF_FFFF, 2'b01, (w_go_rd ? 2'b10 : 2'b01), w_go_phy, w_go_reg,
                 (w_go_rd ? 18'h3FFFF : {2'b10, w_go_wd})};

      case (r_state)
         S_IDLE: ;
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         S_PRE, S_CMD, S_TA, S_DATA: begin
            if (r_div == DIV_LAST) begin
               w_div_nxt = '0;
               w_mdc_nxt = ~r_mdc;
               if (!r_mdc) begin
                  // Rising MDC edge: PHY data is stable here
                  if (r_rd && r_bit == 6'd47) w_ta_bad_nxt = mdio_i;
                  if (r_rd && r_bit >= 6'd48) w_rx_nxt = {r_rx[14:0], mdio_i};
               end else if (r_bit == 6'd63) begin
                  w_state_nxt = S_DONE;
                  w_busy_nxt  = 1'b0;
                  w_mdc_nxt   = 1'b0;
                  w_oe_nxt    = 1'b0;
                  w_mdio_nxt  = 1'b1;
`ifdef IOB_ETH_MDIO_SCAN_EN
                  if (r_scan) begin
                     w_nvalid_nxt   = 1'b0;
                     w_linkfail_nxt = r_ta_bad | ~r_rx[2];
                  end else
`endif
                  begin
                     w_done_nxt = 1'b1;
                     if (r_rd) begin
                        w_ta_err_nxt = r_ta_bad;
                        w_rdata_nxt  = r_ta_bad ? 16'hFFFF : r_rx;
                     end
                  end
               end else begin
                  w_bit_nxt   = r_bit + 6'd1;
                  w_shift_nxt = {r_shift[61:0], 1'b1};
                  w_mdio_nxt  = r_shift[62];
                  w_oe_nxt    = !(r_rd && r_bit >= 6'd45);
                  if (r_bit == 6'd31)      w_state_nxt = S_CMD;
                  else if (r_bit == 6'd45) w_state_nxt = S_TA;
                  else if (r_bit == 6'd47) w_state_nxt = S_DATA;
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_go) begin
         w_state_nxt = S_PRE;
         w_busy_nxt  = 1'b1;
         w_mdc_nxt   = 1'b0;
         w_oe_nxt    = 1'b1;
         w_mdio_nxt  = w_frame[63];
         w_div_nxt   = '0;
         w_bit_nxt   = '0;
         w_shift_nxt = w_frame[62:0];
         w_rd_nxt    = w_go_rd;
`ifdef IOB_ETH_MDIO_SCAN_EN
         w_scan_nxt  = w_go_scan;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state  <= S_IDLE;
         r_div    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_rx     <= '0;
         r_rdata  <= '0;
         r_mdc    <= 1'b0;
         r_mdio   <= 1'b1;
         r_oe     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rd     <= 1'b0;
         r_ta_bad <= 1'b0;
         r_ta_err <= 1'b0;
`ifdef IOB_ETH_MDIO_SCAN_EN
         r_scan      <= 1'b0;
         r_nvalid    <= 1'b1;
         r_linkfail  <= 1'b0;
         r_scan_en_q <= 1'b0;
         r_scan_pend <= 1'b0;
`endif
      end else if (cke_i) begin
         r_state  <= w_state_nxt;
         r_div    <= w_div_nxt;
         r_bit    <= w_bit_nxt;
         r_shift  <= w_shift_nxt;
         r_rx     <= w_rx_nxt;
         r_rdata  <= w_rdata_nxt;
         r_mdc    <= w_mdc_nxt;
         r_mdio   <= w_mdio_nxt;
         r_oe     <= w_oe_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_rd     <= w_rd_nxt;
         r_ta_bad <= w_ta_bad_nxt;
         r_ta_err <= w_ta_err_nxt;
`ifdef IOB_ETH_MDIO_SCAN_EN
         r_scan      <= w_scan_nxt;
         r_nvalid    <= w_nvalid_nxt;
         r_linkfail  <= w_linkfail_nxt;
         r_scan_en_q <= scan_en_i;
         r_scan_pend <= w_scan_pend_nxt;
`endif
      end
   end

   assign rdata_o   = r_rdata;
   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign ta_err_o  = r_ta_err;
   assign mdc_o     = r_mdc;
   assign mdio_o    = r_mdio;
   assign mdio_oe_o = r_oe;
`ifdef IOB_ETH_MDIO_SCAN_EN
   assign nvalid_o   = r_nvalid;
   assign linkfail_o = r_linkfail;
`else
   assign nvalid_o   = 1'b0;
   assign linkfail_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_mdio.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_eth_mdio
// Description : Scoreboard bench for iob_eth_mdio with a behavioural PHY.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iob_eth_mdio;

   localparam int CLK_DIV  = 4;
   localparam int BUSY_CYC = 128 * CLK_DIV;

   logic        clk_i = 1'b0;
   logic        arst_n_i;
   logic        cke_i;
   logic        start_i;
   logic        op_rd_i;
   logic [4:0]  phy_addr_i;
   logic [4:0]  reg_addr_i;
   logic [15:0] wdata_i;
   logic [15:0] rdata_o;
   logic        busy_o;
   logic        done_o;
   logic        ta_err_o;
   logic        scan_en_i;
   logic [4:0]  scan_phy_addr_i;
   logic        nvalid_o;
   logic        linkfail_o;
   logic        mdc_o;
   logic        mdio_o;
   logic        mdio_oe_o;
   logic        mdio_i;

   iob_eth_mdio #(.CLK_DIV(CLK_DIV), .SCAN_REG(5'd1)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .start_i(start_i),
      .op_rd_i(op_rd_i), .phy_addr_i(phy_addr_i), .reg_addr_i(reg_addr_i),
      .wdata_i(wdata_i), .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o),
      .ta_err_o(ta_err_o), .scan_en_i(scan_en_i), .scan_phy_addr_i(scan_phy_addr_i),
      .nvalid_o(nvalid_o), .linkfail_o(linkfail_o), .mdc_o(mdc_o), .mdio_o(mdio_o),
      .mdio_oe_o(mdio_oe_o), .mdio_i(mdio_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rd;
      logic [63:0] frame;
      logic [15:0] rdata;
      logic        ta_err;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_vec = 0;
   int          n_miss = 0;
   logic        exp_ta = 1'b0;
   logic [15:0] exp_rd = 16'h0;
   logic [15:0] phy_data = 16'h0;
   logic        phy_absent = 1'b0;

   int          bitcnt = 0;
   int          busy_cycles = 0;
   logic        prev_mdc = 1'b0;
   logic        prev_busy = 1'b0;
   logic [63:0] cap_bits = '0;
   logic [63:0] cap_oe = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor + PHY model: frame capture per MDC rising edge, checks on done_o
   always @(negedge clk_i) begin
      if (!busy_o) begin
         bitcnt   = 0;
         prev_mdc = 1'b0;
      end else begin
         if (!prev_busy) begin
            busy_cycles = 0;
            cap_bits    = '0;
            cap_oe      = '0;
         end
         busy_cycles++;
         if (!prev_mdc && mdc_o && bitcnt < 64) begin
            cap_bits[63-bitcnt] = mdio_o;
            cap_oe[63-bitcnt]   = mdio_oe_o;
         end
         if (prev_mdc && !mdc_o) bitcnt++;
         prev_mdc = mdc_o;
      end
      prev_busy = busy_o;

      if (phy_absent)                       mdio_i = 1'b1;
      else if (bitcnt == 47)                mdio_i = 1'b0;
      else if (bitcnt >= 48 && bitcnt < 64) mdio_i = phy_data[63-bitcnt];
      else                                  mdio_i = 1'b1;

      if (done_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("done_outs", {busy_o, mdc_o, mdio_oe_o, mdio_o}, 4'b0001);
            chk("busy_len", busy_cycles, BUSY_CYC);
            if (e.rd) begin
               chk("rd_header", cap_bits[63:18], e.frame[63:18]);
               chk("rd_oe", cap_oe, {{46{1'b1}}, {18{1'b0}}});
            end else begin
               chk("wr_frame", cap_bits, e.frame);
               chk("wr_oe", cap_oe, {64{1'b1}});
            end
            chk("rdata", rdata_o, e.rdata);
            chk("ta_err", ta_err_o, e.ta_err);
         end
      end
   end

   task automatic issue(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input bit push);
      exp_t x;
      if (push) begin
         if (rd) begin
            exp_ta = phy_absent;
            exp_rd = phy_absent ? 16'hFFFF : phy_data;
         end
         x.rd     = rd;
         x.frame  = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), pa, ra, 2'b10, wd};
         x.rdata  = exp_rd;
         x.ta_err = exp_ta;
         sb.push_back(x);
      end
      start_i    = 1'b1;
      op_rd_i    = rd;
      phy_addr_i = pa;
      reg_addr_i = ra;
      wdata_i    = wd;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_sb_empty();
      int t = 0;
      while ((sb.size() != 0 || busy_o) && t < 4000) begin
         @(negedge clk_i);
         t++;
      end
      chk("txn_timeout", (sb.size() != 0 || busy_o), 0);
      repeat (2) @(negedge clk_i);
   endtask

   task automatic wait_busy(input logic lvl);
      int t = 0;
      while (busy_o !== lvl && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      chk("busy_wait_timeout", busy_o, lvl);
   endtask

   task automatic do_reset();
      arst_n_i = 1'b0;
      repeat (3) @(negedge clk_i);
      arst_n_i = 1'b1;
      exp_ta = 1'b0;
      exp_rd = 16'h0;
      @(negedge clk_i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n_i = 1'b0; cke_i = 1'b1; start_i = 1'b0; op_rd_i = 1'b0;
      phy_addr_i = '0; reg_addr_i = '0; wdata_i = '0;
      scan_en_i = 1'b0; scan_phy_addr_i = 5'd7;
      repeat (3) @(negedge clk_i);
      chk("reset_outs", {busy_o, mdc_o, mdio_oe_o, mdio_o, done_o, ta_err_o, linkfail_o},
          7'b0001000);
      chk("reset_rdata", rdata_o, 16'h0);
`ifdef IOB_ETH_MDIO_SCAN_EN
      chk("reset_nvalid", nvalid_o, 1'b1);
`else
      chk("reset_nvalid", nvalid_o, 1'b0);
`endif
      arst_n_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // Write phy=1 reg=0 data 1140
      issue(1'b0, 5'd1, 5'd0, 16'h1140, 1'b1);
      wait_sb_empty();

      // Read with a responding PHY
      phy_absent = 1'b0; phy_data = 16'h796D;
      issue(1'b1, 5'd3, 5'd2, 16'h0, 1'b1);
      wait_sb_empty();

      // Read with no PHY: TA error
      phy_absent = 1'b1;
      issue(1'b1, 5'd4, 5'd1, 16'h0, 1'b1);
      wait_sb_empty();
      phy_absent = 1'b0;

      // Write with a competing start mid-frame that must be dropped
      issue(1'b0, 5'd5, 5'd4, 16'hABCD, 1'b1);
      repeat (200) @(negedge clk_i);
      start_i = 1'b1; op_rd_i = 1'b1; phy_addr_i = 5'd9; reg_addr_i = 5'd9; wdata_i = 16'h0;
      repeat (3) @(negedge clk_i);
      start_i = 1'b0;
      wait_sb_empty();
      repeat (10) @(negedge clk_i);
      chk("no_queued_start", busy_o, 1'b0);

      // Reset during the DATA phase of a read
      phy_data = 16'hA5C3;
      issue(1'b1, 5'd3, 5'd2, 16'h0, 1'b0);
      begin
         int t = 0;
         while (bitcnt < 50 && t < 3000) begin
            @(negedge clk_i);
            t++;
         end
      end
      chk("reach_data_phase", (bitcnt >= 50), 1);
      #1 arst_n_i = 1'b0;
      #1;
      chk("abort_outs", {busy_o, mdc_o, mdio_oe_o, mdio_o, done_o, ta_err_o}, 6'b000100);
      chk("abort_rdata", rdata_o, 16'h0);
      @(negedge clk_i);
      do_reset();

      phy_data = 16'h5A3C;
      issue(1'b1, 5'd3, 5'd2, 16'h0, 1'b1);
      wait_sb_empty();

`ifdef IOB_ETH_MDIO_SCAN_EN
      do_reset();
      chk("scan_nvalid_init", nvalid_o, 1'b1);
      phy_data = 16'h7809;
      scan_en_i = 1'b1;
      issue(1'b0, 5'd2, 5'd3, 16'h0F0F, 1'b1);
      wait_sb_empty();
      wait_busy(1'b1);
      wait_busy(1'b0);
      chk("scan1_status", {nvalid_o, linkfail_o, done_o, ta_err_o}, 4'b0100);
      chk("scan1_rdata", rdata_o, 16'h0);
      phy_data = 16'h782D;
      wait_busy(1'b1);
      wait_busy(1'b0);
      chk("scan2_status", {nvalid_o, linkfail_o, done_o}, 3'b000);
      scan_en_i = 1'b0;
      repeat (6) @(negedge clk_i);
      chk("scan_off_nvalid", {nvalid_o, busy_o}, 2'b10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
